hyper_lsab_cw: RTL and testbench

HYPER_LSAB_CW -- requirements
Module: hyper_lsab_cw

---
 rtl/hyper_lsab_cw.sv | 150 +++++++++++++++
 tb/tb_hyper_lsab_cw.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyper_lsab_cw.sv
// hyper_lsab_cw: four-section load/store assist buffer.
// Four independent circular FIFOs share one RAM indexed {section, pointer}.
// The DRAM block mover writes into a section; the fabric pops from a section.
//
// Ports:
//   CLK           sole clock, rising edge
//   RST           asynchronous active-low reset
//   LSAB_WRITE    write strobe
//   LSAB_SECTION  section addressed by the write
//   INDATA        write data
//   READ          read strobe
//   READ_SECTION  section addressed by the read
//   OUTDATA       registered read data, holds when no read is accepted
//   OUT_VALID     one-cycle pulse with each freshly popped word
//   FLUSH         per-section discard (rptr := wptr, sticky flags cleared)
//   EMPTY/FULL/AFULL         per-section registered status
//   OVERFLOW/UNDERFLOW       per-section sticky error flags
module hyper_lsab_cw #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned SEC_DEPTH_LOG2 = 5,
    parameter int unsigned AFULL_LEVEL    = 24
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  LSAB_WRITE,
    input  logic [1:0]            LSAB_SECTION,
    input  logic [DATA_WIDTH-1:0] INDATA,
    input  logic                  READ,
    input  logic [1:0]            READ_SECTION,
    output logic [DATA_WIDTH-1:0] OUTDATA,
    output logic                  OUT_VALID,
    input  logic [3:0]            FLUSH,
    output logic [3:0]            EMPTY,
    output logic [3:0]            FULL,
    output logic [3:0]            AFULL,
    output logic [3:0]            OVERFLOW,
    output logic [3:0]            UNDERFLOW
);

    localparam int unsigned PW        = SEC_DEPTH_LOG2 + 1;
    localparam int unsigned SEC_DEPTH = 2 ** SEC_DEPTH_LOG2;

    logic [DATA_WIDTH-1:0] mem [0:4*SEC_DEPTH-1];

    logic [PW-1:0] wptr_q [4];
    logic [PW-1:0] wptr_d [4];
    logic [PW-1:0] rptr_q [4];
    logic [PW-1:0] rptr_d [4];
    logic [PW-1:0] fill   [4];

    logic [3:0] empty_q, empty_d;
    logic [3:0] full_q, full_d;
    logic [3:0] afull_q, afull_d;
    logic [3:0] ovf_q, ovf_d;
    logic [3:0] unf_q, unf_d;

    logic [DATA_WIDTH-1:0] outdata_q;
    logic                  out_valid_q;

    logic wr_acc;
    logic rd_acc;

    // Decisions use the registered flags, i.e. the pre-cycle pointers. A flush
    // of the written section makes room, so the write lands as its only word.
    assign wr_acc = LSAB_WRITE && (!full_q[LSAB_SECTION] || FLUSH[LSAB_SECTION]);
    assign rd_acc = READ && !empty_q[READ_SECTION] && !FLUSH[READ_SECTION];

    always_comb begin
        empty_d = '0;
        full_d  = '0;
        afull_d = '0;
        ovf_d   = '0;
        unf_d   = '0;
        for (int s = 0; s < 4; s++) begin
            wptr_d[s] = wptr_q[s];
            rptr_d[s] = rptr_q[s];
            if (wr_acc && (LSAB_SECTION == 2'(s))) begin
                wptr_d[s] = wptr_q[s] + 1'b1;
            end
            // Flush takes the pre-write wptr, so a same-cycle write survives.
            if (FLUSH[s]) begin
                rptr_d[s] = wptr_q[s];
            end else if (rd_acc && (READ_SECTION == 2'(s))) begin
                rptr_d[s] = rptr_q[s] + 1'b1;
            end

            if (FLUSH[s]) begin
                ovf_d[s] = 1'b0;
                unf_d[s] = 1'b0;
            end else begin
                ovf_d[s] = ovf_q[s] |
                           (LSAB_WRITE && (LSAB_SECTION == 2'(s)) && full_q[s]);
                unf_d[s] = unf_q[s] |
                           (READ && (READ_SECTION == 2'(s)) && empty_q[s]);
            end

            fill[s]    = wptr_d[s] - rptr_d[s];
            empty_d[s] = (wptr_d[s] == rptr_d[s]);
            full_d[s]  = (wptr_d[s][SEC_DEPTH_LOG2-1:0] == rptr_d[s][SEC_DEPTH_LOG2-1:0]) &&
                         (wptr_d[s][SEC_DEPTH_LOG2] != rptr_d[s][SEC_DEPTH_LOG2]);
            afull_d[s] = (32'(fill[s]) >= AFULL_LEVEL);
        end
    end

    // Storage array: not reset.
    always_ff @(posedge CLK) begin
        if (wr_acc) begin
            mem[{LSAB_SECTION, wptr_q[LSAB_SECTION][SEC_DEPTH_LOG2-1:0]}] <= INDATA;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int s = 0; s < 4; s++) begin
                wptr_q[s] <= '0;
                rptr_q[s] <= '0;
            end
            empty_q     <= 4'hF;
            full_q      <= '0;
            afull_q     <= '0;
            ovf_q       <= '0;
            unf_q       <= '0;
            outdata_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            for (int s = 0; s < 4; s++) begin
                wptr_q[s] <= wptr_d[s];
                rptr_q[s] <= rptr_d[s];
            end
            empty_q     <= empty_d;
            full_q      <= full_d;
            afull_q     <= afull_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            out_valid_q <= rd_acc;
            if (rd_acc) begin
                outdata_q <= mem[{READ_SECTION, rptr_q[READ_SECTION][SEC_DEPTH_LOG2-1:0]}];
            end
        end
    end

    assign OUTDATA   = outdata_q;
    assign OUT_VALID = out_valid_q;
    assign EMPTY     = empty_q;
    assign FULL      = full_q;
    assign AFULL     = afull_q;
    assign OVERFLOW  = ovf_q;
    assign UNDERFLOW = unf_q;

endmodule

// File: tb/tb_hyper_lsab_cw.sv
module tb_hyper_lsab_cw;

    logic        CLK;
    logic        RST;
    logic        LSAB_WRITE;
    logic [1:0]  LSAB_SECTION;
    logic [31:0] INDATA;
    logic        READ;
    logic [1:0]  READ_SECTION;
    logic [31:0] OUTDATA;
    logic        OUT_VALID;
    logic [3:0]  FLUSH;
    logic [3:0]  EMPTY;
    logic [3:0]  FULL;
    logic [3:0]  AFULL;
    logic [3:0]  OVERFLOW;
    logic [3:0]  UNDERFLOW;

    int vectors;
    int errors;

    hyper_lsab_cw #(
        .DATA_WIDTH     (32),
        .SEC_DEPTH_LOG2 (5),
        .AFULL_LEVEL    (24)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .LSAB_WRITE   (LSAB_WRITE),
        .LSAB_SECTION (LSAB_SECTION),
        .INDATA       (INDATA),
        .READ         (READ),
        .READ_SECTION (READ_SECTION),
        .OUTDATA      (OUTDATA),
        .OUT_VALID    (OUT_VALID),
        .FLUSH        (FLUSH),
        .EMPTY        (EMPTY),
        .FULL         (FULL),
        .AFULL        (AFULL),
        .OVERFLOW     (OVERFLOW),
        .UNDERFLOW    (UNDERFLOW)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        RST = 1'b0;
        tick();
        tick();
        RST = 1'b1;
    endtask

    task automatic do_write(input logic [1:0] sec, input logic [31:0] data);
        LSAB_WRITE = 1'b1; LSAB_SECTION = sec; INDATA = data;
        tick();
        LSAB_WRITE = 1'b0;
    endtask

    task automatic do_read(input logic [1:0] sec);
        READ = 1'b1; READ_SECTION = sec;
        tick();
        READ = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if ({EMPTY, FULL, AFULL, OVERFLOW, UNDERFLOW} !== 20'hF0000) begin
            errors++;
            $display("FAIL reset_flags: got E=%h F=%h AF=%h OV=%h UN=%h, want E=f rest 0",
                     EMPTY, FULL, AFULL, OVERFLOW, UNDERFLOW);
        end
        vectors++;
        if (OUT_VALID !== 1'b0 || OUTDATA !== 32'h0) begin
            errors++;
            $display("FAIL reset_out: got valid=%b data=%h, want 0/0", OUT_VALID, OUTDATA);
        end
    endtask

    task automatic test_basic();
        logic [31:0] exp [3];
        exp[0] = 32'h11; exp[1] = 32'h22; exp[2] = 32'h33;
        apply_reset();
        for (int i = 0; i < 3; i++) do_write(2'd2, exp[i]);
        vectors++;
        if (EMPTY !== 4'b1011) begin
            errors++;
            $display("FAIL basic_not_empty: got EMPTY=%b, want 1011", EMPTY);
        end
        for (int i = 0; i < 3; i++) begin
            do_read(2'd2);
            vectors++;
            if (OUT_VALID !== 1'b1 || OUTDATA !== exp[i]) begin
                errors++;
                $display("FAIL basic_read%0d: got valid=%b data=%h, want 1/%h",
                         i, OUT_VALID, OUTDATA, exp[i]);
            end
        end
        tick();
        vectors++;
        if (OUT_VALID !== 1'b0 || OUTDATA !== 32'h33 || EMPTY !== 4'hF) begin
            errors++;
            $display("FAIL basic_idle: got valid=%b data=%h EMPTY=%b, want 0/33/1111",
                     OUT_VALID, OUTDATA, EMPTY);
        end
    endtask

    task automatic test_no_bypass();
        apply_reset();
        LSAB_WRITE = 1'b1; LSAB_SECTION = 2'd2; INDATA = 32'h77;
        READ = 1'b1; READ_SECTION = 2'd2;
        tick();
        LSAB_WRITE = 1'b0; READ = 1'b0;
        vectors++;
        if (OUT_VALID !== 1'b0 || UNDERFLOW !== 4'b0100 || OUTDATA !== 32'h0) begin
            errors++;
            $display("FAIL nobypass_same: got valid=%b UN=%b data=%h, want 0/0100/0",
                     OUT_VALID, UNDERFLOW, OUTDATA);
        end
        do_read(2'd2);
        vectors++;
        if (OUT_VALID !== 1'b1 || OUTDATA !== 32'h77) begin
            errors++;
            $display("FAIL nobypass_next: got valid=%b data=%h, want 1/77", OUT_VALID, OUTDATA);
        end
    endtask

    task automatic test_full();
        apply_reset();
        for (int k = 1; k <= 32; k++) begin
            do_write(2'd0, 32'h100 + 32'(k - 1));
            if (k == 23 || k == 24) begin
                vectors++;
                if (AFULL[0] !== (k == 24)) begin
                    errors++;
                    $display("FAIL full_afull_k%0d: got AFULL[0]=%b, want %b",
                             k, AFULL[0], (k == 24));
                end
            end
            if (k == 31 || k == 32) begin
                vectors++;
                if (FULL !== ((k == 32) ? 4'b0001 : 4'b0000)) begin
                    errors++;
                    $display("FAIL full_flag_k%0d: got FULL=%b", k, FULL);
                end
            end
        end
        do_write(2'd0, 32'hDEAD);
        vectors++;
        if (OVERFLOW !== 4'b0001 || FULL !== 4'b0001) begin
            errors++;
            $display("FAIL full_overflow: got OV=%b FULL=%b, want 0001/0001", OVERFLOW, FULL);
        end
        for (int i = 0; i < 32; i++) begin
            do_read(2'd0);
            vectors++;
            if (OUT_VALID !== 1'b1 || OUTDATA !== 32'h100 + 32'(i)) begin
                errors++;
                $display("FAIL full_drain%0d: got valid=%b data=%h, want 1/%h",
                         i, OUT_VALID, OUTDATA, 32'h100 + 32'(i));
            end
        end
        vectors++;
        if (EMPTY !== 4'hF || AFULL !== 4'h0 || OVERFLOW !== 4'b0001) begin
            errors++;
            $display("FAIL full_after: got E=%b AF=%b OV=%b, want 1111/0000/0001",
                     EMPTY, AFULL, OVERFLOW);
        end
    endtask

    task automatic test_underflow();
        apply_reset();
        do_read(2'd3);
        vectors++;
        if (UNDERFLOW !== 4'b1000 || OUT_VALID !== 1'b0) begin
            errors++;
            $display("FAIL underflow_set: got UN=%b valid=%b, want 1000/0", UNDERFLOW, OUT_VALID);
        end
        FLUSH = 4'b1000;
        tick();
        FLUSH = 4'b0000;
        vectors++;
        if (UNDERFLOW !== 4'b0000) begin
            errors++;
            $display("FAIL underflow_flush: got UN=%b, want 0000", UNDERFLOW);
        end
    endtask

    task automatic test_wrap();
        int rd_n;
        apply_reset();
        rd_n = 0;
        for (int i = 0; i < 3; i++) do_write(2'd1, 32'h1000 + 32'(i));
        for (int i = 0; i < 97; i++) begin
            LSAB_WRITE = 1'b1; LSAB_SECTION = 2'd1; INDATA = 32'h1003 + 32'(i);
            READ = 1'b1; READ_SECTION = 2'd1;
            tick();
            LSAB_WRITE = 1'b0; READ = 1'b0;
            vectors++;
            if (OUT_VALID !== 1'b1 || OUTDATA !== 32'h1000 + 32'(rd_n) || EMPTY[1] !== 1'b0) begin
                errors++;
                $display("FAIL wrap_rw%0d: got valid=%b data=%h E1=%b, want 1/%h/0",
                         i, OUT_VALID, OUTDATA, EMPTY[1], 32'h1000 + 32'(rd_n));
            end
            rd_n++;
        end
        for (int i = 0; i < 3; i++) begin
            do_read(2'd1);
            vectors++;
            if (OUT_VALID !== 1'b1 || OUTDATA !== 32'h1000 + 32'(rd_n)) begin
                errors++;
                $display("FAIL wrap_tail%0d: got valid=%b data=%h, want 1/%h",
                         i, OUT_VALID, OUTDATA, 32'h1000 + 32'(rd_n));
            end
            rd_n++;
        end
        vectors++;
        if (EMPTY !== 4'hF || OVERFLOW !== 4'h0 || UNDERFLOW !== 4'h0 || FULL !== 4'h0) begin
            errors++;
            $display("FAIL wrap_flags: got E=%b OV=%b UN=%b F=%b, want 1111/0/0/0",
                     EMPTY, OVERFLOW, UNDERFLOW, FULL);
        end
    endtask

    task automatic test_cross();
        apply_reset();
        for (int i = 0; i < 8; i++) do_write(2'd1, 32'h500 + 32'(i));
        for (int i = 0; i < 8; i++) begin
            LSAB_WRITE = 1'b1; LSAB_SECTION = 2'd0; INDATA = 32'h600 + 32'(i);
            READ = 1'b1; READ_SECTION = 2'd1;
            tick();
            LSAB_WRITE = 1'b0; READ = 1'b0;
            vectors++;
            if (OUT_VALID !== 1'b1 || OUTDATA !== 32'h500 + 32'(i)) begin
                errors++;
                $display("FAIL cross_s1_%0d: got valid=%b data=%h, want 1/%h",
                         i, OUT_VALID, OUTDATA, 32'h500 + 32'(i));
            end
        end
        for (int i = 0; i < 8; i++) begin
            do_read(2'd0);
            vectors++;
            if (OUT_VALID !== 1'b1 || OUTDATA !== 32'h600 + 32'(i)) begin
                errors++;
                $display("FAIL cross_s0_%0d: got valid=%b data=%h, want 1/%h",
                         i, OUT_VALID, OUTDATA, 32'h600 + 32'(i));
            end
        end
        vectors++;
        if (EMPTY !== 4'hF || OVERFLOW !== 4'h0 || UNDERFLOW !== 4'h0) begin
            errors++;
            $display("FAIL cross_flags: got E=%b OV=%b UN=%b", EMPTY, OVERFLOW, UNDERFLOW);
        end
    endtask

    task automatic test_flush_write();
        apply_reset();
        do_write(2'd2, 32'h1);
        do_write(2'd2, 32'h2);
        FLUSH = 4'b0100;
        LSAB_WRITE = 1'b1; LSAB_SECTION = 2'd2; INDATA = 32'hAB;
        READ = 1'b1; READ_SECTION = 2'd2;
        tick();
        FLUSH = 4'b0000; LSAB_WRITE = 1'b0; READ = 1'b0;
        vectors++;
        if (OUT_VALID !== 1'b0 || UNDERFLOW !== 4'h0 || EMPTY !== 4'b1011) begin
            errors++;
            $display("FAIL flush_same: got valid=%b UN=%b E=%b, want 0/0000/1011",
                     OUT_VALID, UNDERFLOW, EMPTY);
        end
        do_read(2'd2);
        vectors++;
        if (OUT_VALID !== 1'b1 || OUTDATA !== 32'hAB || EMPTY !== 4'hF) begin
            errors++;
            $display("FAIL flush_word: got valid=%b data=%h E=%b, want 1/ab/1111",
                     OUT_VALID, OUTDATA, EMPTY);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < 11; i++) do_write(2'd1, 32'h700 + 32'(i));
        do_read(2'd1);
        vectors++;
        if (EMPTY !== 4'b1101 || OUTDATA !== 32'h700) begin
            errors++;
            $display("FAIL mid_loaded: got E=%b data=%h, want 1101/700", EMPTY, OUTDATA);
        end
        #2;
        RST = 1'b0;
        #1;
        vectors++;
        if ({EMPTY, FULL, AFULL, OVERFLOW, UNDERFLOW} !== 20'hF0000 ||
            OUT_VALID !== 1'b0 || OUTDATA !== 32'h0) begin
            errors++;
            $display("FAIL mid_async: got E=%b F=%b AF=%b OV=%b UN=%b v=%b d=%h",
                     EMPTY, FULL, AFULL, OVERFLOW, UNDERFLOW, OUT_VALID, OUTDATA);
        end
        tick();
        RST = 1'b1;
        do_write(2'd1, 32'h99);
        vectors++;
        if (EMPTY !== 4'b1101) begin
            errors++;
            $display("FAIL mid_first_write: got E=%b, want 1101", EMPTY);
        end
        do_read(2'd1);
        vectors++;
        if (OUT_VALID !== 1'b1 || OUTDATA !== 32'h99 || EMPTY !== 4'hF) begin
            errors++;
            $display("FAIL mid_readback: got valid=%b data=%h E=%b, want 1/99/1111",
                     OUT_VALID, OUTDATA, EMPTY);
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        RST = 1'b0; LSAB_WRITE = 1'b0; LSAB_SECTION = 2'd0; INDATA = '0;
        READ = 1'b0; READ_SECTION = 2'd0; FLUSH = 4'b0000;
        test_reset();
        test_basic();
        test_no_bypass();
        test_full();
        test_underflow();
        test_wrap();
        test_cross();
        test_flush_write();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
